// File: rtl/ps2_key_tracker_if.sv
// ----------------------------------------------------------------------------
// ps2_key_tracker_if
// Byte-stream input and event-FIFO pop bundle for ps2_key_tracker.
//   byte_in/byte_valid : raw PS/2 byte and one-cycle strobe from the receiver
//   ev_ready           : consumer accepts the head event
//   ev_valid           : event FIFO non-empty
//   ev_make/ev_ext/ev_code : head event fields
// master = byte source / event consumer, slave = the tracker.
// ----------------------------------------------------------------------------
interface ps2_key_tracker_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       ev_ready;
    logic       ev_valid;
    logic       ev_make;
    logic       ev_ext;
    logic [7:0] ev_code;

    modport master (
        output byte_in, byte_valid, ev_ready,
        input  ev_valid, ev_make, ev_ext, ev_code
    );

    modport slave (
        input  byte_in, byte_valid, ev_ready,
        output ev_valid, ev_make, ev_ext, ev_code
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// ----------------------------------------------------------------------------
// ps2_key_tracker
// Decodes the PS/2 set-2 byte stream (E0 extended / F0 break prefixes), keeps
// a held bitmap for a table of watched keys and queues make/break events in a
// first-word-fall-through FIFO. Typematic repeats of watched keys are dropped.
// Ports:
//   CLOCK_50, resetn : clock, synchronous active-low reset
//   bus              : byte input and event pop handshake (slave modport)
//   clr_overflow     : clears the sticky overflow flag
//   held             : bit i set while watched key i is down
//   ev_count         : FIFO occupancy
//   overflow         : sticky, an event was dropped on a full FIFO
//   last_code        : last completed scan code
// ----------------------------------------------------------------------------
module ps2_key_tracker #(
    parameter int unsigned           NUM_KEYS  = 8,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {NUM_KEYS{9'h000}},
    parameter int unsigned           DEPTH     = 8,
    parameter bit                    PUSH_ALL  = 1'b0
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    ps2_key_tracker_if.slave        bus,
    input  logic                    clr_overflow,
    output logic [NUM_KEYS-1:0]     held,
    output logic [$clog2(DEPTH):0]  ev_count,
    output logic                    overflow,
    output logic [7:0]              last_code
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t                r_state;
    logic [NUM_KEYS-1:0]   r_held;
    logic [EW-1:0]         r_mem [DEPTH];
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ev_valid;
    logic [EW-1:0]         r_head;
    logic                  r_overflow;
    logic [7:0]            r_last_code;

    logic                  w_ignored;
    logic                  w_done;
    logic                  w_make;
    logic                  w_ext;
    logic [NUM_KEYS-1:0]   w_match;
    logic                  w_change;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_drop;
    logic                  w_wr;
    logic [EW-1:0]         w_entry;
    logic [CW-1:0]         w_count_nxt;
    logic [EW-1:0]         w_head_nxt;

    // Byte classification: acknowledgements / self-test / error bytes never complete a code
    assign w_ignored = bus.byte_in inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    assign w_done    = bus.byte_valid && !w_ignored &&
                       (bus.byte_in != 8'hE0) && (bus.byte_in != 8'hF0) && (bus.byte_in != 8'hE1);
    assign w_make    = (r_state == S_IDLE) || (r_state == S_EXT);
    assign w_ext     = (r_state == S_EXT)  || (r_state == S_EXT_BRK);
    assign w_entry   = {w_make, w_ext, bus.byte_in};

    // Watched-key lookup; duplicate table entries all match together
    always_comb begin
        w_match = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            w_match[i] = (KEY_CODES[9*i +: 9] == {w_ext, bus.byte_in});
        end
    end

    // A watched key only generates an event when its held state actually flips
    assign w_change = w_make ? |(w_match & ~r_held) : |(w_match & r_held);
    assign w_push   = w_done && ((|w_match) ? w_change : PUSH_ALL);
    assign w_pop    = r_ev_valid && bus.ev_ready;
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_drop   = w_push && w_full && !w_pop;
    assign w_wr     = w_push && !w_drop;

    // Occupancy and next head-of-queue selection
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end

        w_head_nxt = r_head;
        if (w_pop) begin
            // rd_ptr+1 is already written whenever more than one entry is stored
            if (r_count > CW'(1)) begin
                w_head_nxt = r_mem[r_rd_ptr + AW'(1)];
            end else if (w_wr) begin
                w_head_nxt = w_entry;
            end else begin
                w_head_nxt = '0;
            end
        end else if (w_wr && (r_count == '0)) begin
            w_head_nxt = w_entry;
        end
    end

    // Prefix FSM
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else if (bus.byte_valid) begin
            if (bus.byte_in == 8'hE0) begin
                r_state <= S_EXT;
            end else if (bus.byte_in == 8'hF0) begin
                case (r_state)
                    S_IDLE:  r_state <= S_BRK;
                    S_EXT:   r_state <= S_EXT_BRK;
                    default: r_state <= r_state;
                endcase
            end else if (bus.byte_in == 8'hE1) begin
                r_state <= S_IDLE;
            end else if (!w_ignored) begin
                r_state <= S_IDLE;
            end
        end
    end

    // Event storage; contents need no reset since occupancy gates every read
    always_ff @(posedge CLOCK_50) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Held bitmap, FIFO bookkeeping and status
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_held      <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_ev_valid  <= 1'b0;
            r_head      <= '0;
            r_overflow  <= 1'b0;
            r_last_code <= '0;
        end else begin
            if (w_done) begin
                r_last_code <= bus.byte_in;
                r_held      <= w_make ? (r_held | w_match) : (r_held & ~w_match);
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_ev_valid <= (w_count_nxt != '0);
            r_head     <= w_head_nxt;
            // A drop in the same cycle as a clear must still leave the flag set
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign held         = r_held;
    assign ev_count     = r_count;
    assign overflow     = r_overflow;
    assign last_code    = r_last_code;
    assign bus.ev_valid = r_ev_valid;
    assign bus.ev_make  = r_head[9];
    assign bus.ev_ext   = r_head[8];
    assign bus.ev_code  = r_head[7:0];

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 set-2 key tracker between the byte-level PS/2 receiver and game/display logic. It consumes the raw received byte stream and decodes the `E0` (extended) and `F0` (break) prefixes. It maintains a held-key bitmap for a configurable set of watched keys and buffers make/break events in a first-word-fall-through FIFO with valid/ready pop. Typematic repeats are filtered, so consumers see only real state changes.

## Interface
- `NUM_KEYS`, 8, number of watched keys (1..32).
- `KEY_CODES`, `{NUM_KEYS{9'h000}}`, packed table of watched keys, `NUM_KEYS*9` bits.
  - Entry i is bits `[9i+8:9i]`.
  - Bit 8 is the extended flag; bits 7:0 are the scan code.
- `DEPTH`, 8, event FIFO depth; must be a power of two, 2..64.
- `PUSH_ALL`, 0.
  - 1: every completed code produces an event.
  - 0: only watched-key state changes produce events.
- `CLOCK_50`  in  1  single clock; all logic on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `byte_in`  in  8  received PS/2 byte.
- `byte_valid`  in  1  one-cycle strobe: `byte_in` is valid.
- `ev_ready`  in  1  consumer accepts the head event.
- `clr_overflow`  in  1  clears `overflow`.
- `held`  out  NUM_KEYS  bit i is 1 while watched key i is down.
- `ev_valid`  out  1  FIFO non-empty.
- `ev_make`  out  1  head event: 1 = press, 0 = release.
- `ev_ext`  out  1  head event carries the extended flag.
- `ev_code`  out  8  head event scan code.
- `ev_count`  out  clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.
- `last_code`  out  8  last completed scan code, for the HEX display.

## Operation
- Prefix FSM states: `IDLE`, `EXT` (after `E0`), `BRK` (after `F0`), `EXT_BRK` (after `E0 F0`).
- The FSM advances only on cycles with `byte_valid`=1.
- Transitions on an accepted byte:
  - `E0`: from `IDLE` goes to `EXT`; from any other state goes to `EXT` and discards the pending prefix.
  - `F0`: `IDLE`→`BRK`; `EXT`→`EXT_BRK`; from `BRK` or `EXT_BRK`, stays in that state.
  - `E1`: goes to `IDLE`; the byte is discarded (pause sequences are not supported).
  - `AA`, `FA`, `FE`, `EE`, `00`, `FF`: ignored, state unchanged.
  - Any other byte completes a code and returns the FSM to `IDLE`.
    - make = not in `BRK`/`EXT_BRK`.
    - ext = in `EXT`/`EXT_BRK`.
- Completed code handling:
  - `last_code` ← code.
  - Compare {ext, code} against every `KEY_CODES` entry.
  - If several entries match, all matching `held` bits update.
- Watched key:
  - make with `held[i]`=0: set `held[i]`, push an event.
  - make with `held[i]`=1: typematic repeat; no push.
  - break with `held[i]`=1: clear `held[i]`, push an event.
  - break with `held[i]`=0: no push.
- Unwatched key: push only if `PUSH_ALL`=1; repeats are not filtered.
- Event FIFO:
  - Entry = {make, ext, code}, 10 bits.
  - Pop when `ev_valid & ev_ready`.
  - Push and pop in the same cycle are always legal, including when full: count unchanged, no drop.
  - Push while full without pop: the event is dropped, `overflow` ← 1, and `held` still updates.
  - Pop while empty: no effect.
  - Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- `overflow`: `clr_overflow`=1 clears it. If a drop and `clr_overflow` occur in the same cycle, the drop wins (`overflow`=1).

## Timing
- Reset (`resetn`=0 at a clock edge) forces:
  - FSM → `IDLE`.
  - `held`=0, FIFO emptied (`ev_valid`=0, `ev_count`=0).
  - `ev_make`/`ev_ext`/`ev_code`=0, `overflow`=0, `last_code`=0.
- Reset mid-sequence discards any pending prefix.
- Latency: code byte accepted at edge t → `held`, `last_code` and, if the FIFO was empty, `ev_valid`/head fields are visible after edge t, one cycle.
- Head fields change only on the edge after a pop or on a push into an empty FIFO; they are stable while `ev_valid`=1 and `ev_ready`=0.
- `ev_count` is registered and reflects pushes/pops from the previous edge.
- Back-to-back `byte_valid` on consecutive cycles must be supported.

## Test plan
- **Press/release:** key0=`9'h01D`; bytes `1D`, `F0 1D`.
  - `held[0]` 1 then 0.
  - Events {1,0,1D} then {0,0,1D}.
  - `last_code`=`1D`.
- **Extended and typematic:** key1=`9'h175` (up arrow); bytes `E0 75` ×3, then `E0 F0 75`.
  - Exactly 2 events: {1,1,75} and {0,1,75}.
  - A non-extended `75` does not touch `held[1]`.
- **Overflow:** DEPTH=4, `ev_ready`=0, 5 distinct watched presses.
  - `ev_count`=4, `overflow`=1, all 5 `held` bits set.
  - `clr_overflow` then clears the flag.
- **Full with simultaneous push/pop:** FIFO full, `ev_ready`=1 on the cycle a new event completes.
  - No drop, `ev_count` stays 4.
  - Order is preserved across pointer wrap.
- **`PUSH_ALL`=1:** unwatched `1C` make → event {1,0,1C}, `held` unchanged.
- **Reset mid-sequence:** bytes `E0 F0`, `resetn` low 1 cycle, then `1D`.
  - After reset, `1D` decodes as a plain make.
  - All outputs zero during reset.
